// File: rtl/alu_result_collector_if.sv
// Result stream between the collector and its consumer.
// The collector drives valid/data; the consumer drives ready.
interface alu_result_collector_if;
  logic              out_valid;
  logic              out_ready;
  logic signed [5:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/alu_result_collector.sv
// Captures ALU results one cycle after alu_en, queues them in a show-ahead FIFO,
// and keeps a saturating running sum plus a saturating drop counter.
module alu_result_collector #(
  parameter int DEPTH = 4,
  parameter int ACC_W = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      alu_en,
  input  logic signed [5:0]         c,
  alu_result_collector_if.master    out_if,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic signed [ACC_W-1:0]   acc,
  output logic                      acc_sat,
  output logic [7:0]                drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // Returns {clamped, value}; the ACC_W+1 sum can never itself overflow.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [5:0] b);
    logic [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {{(ACC_W-5){b[5]}}, b};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      if (sum[ACC_W]) begin
        sat_add = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sat_add = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      sat_add = {1'b0, sum[ACC_W-1:0]};
    end
  endfunction

  logic                    en_q, en_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    acc_sat_q, acc_sat_d;
  logic [7:0]              drop_cnt_q, drop_cnt_d;
  logic signed [5:0]       mem_q [DEPTH];

  logic                    full_s;
  logic                    pop_s;
  logic                    push_s;
  logic                    drop_s;
  logic                    mem_we_s;
  logic [ACC_W:0]          sum_s;

  // Handshake decode: a pop frees a slot for a same-cycle push when full.
  always_comb begin
    full_s   = (level_q == LW'(DEPTH));
    pop_s    = (level_q != {LW{1'b0}}) && out_if.out_ready;
    push_s   = en_q && (!full_s || pop_s);
    drop_s   = en_q && full_s && !pop_s;
    mem_we_s = push_s && !clr;
  end

  // Next-state logic; clr overrides every other update in its cycle.
  always_comb begin
    en_d       = alu_en;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    acc_d      = acc_q;
    acc_sat_d  = acc_sat_q;
    drop_cnt_d = drop_cnt_q;
    sum_s      = sat_add(acc_q, c);
    if (clr) begin
      en_d       = 1'b0;
      rd_ptr_d   = {PW{1'b0}};
      wr_ptr_d   = {PW{1'b0}};
      level_d    = {LW{1'b0}};
      acc_d      = {ACC_W{1'b0}};
      acc_sat_d  = 1'b0;
      drop_cnt_d = 8'd0;
    end else begin
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        acc_d     = sum_s[ACC_W-1:0];
        acc_sat_d = acc_sat_q | sum_s[ACC_W];
      end else begin
        wr_ptr_d  = wr_ptr_q;
      end
      if (drop_s && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      level_q    <= {LW{1'b0}};
      acc_q      <= {ACC_W{1'b0}};
      acc_sat_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      en_q       <= en_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      acc_q      <= acc_d;
      acc_sat_q  <= acc_sat_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage array; contents are meaningless until written, so it has no reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= c;
    end
  end

  assign out_if.out_valid = (level_q != {LW{1'b0}});
  assign out_if.out_data  = mem_q[rd_ptr_q];
  assign level            = level_q;
  assign full             = full_s;
  assign acc              = acc_q;
  assign acc_sat          = acc_sat_q;
  assign drop_cnt         = drop_cnt_q;

endmodule
